// File: rtl/bram_row_loader_pkg.sv
// Shared types and constants for the stereo row loader and its consumers.
package bram_row_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRELOAD_LO,
    PRELOAD_HI,
    LOAD_LO,
    LOAD_HI,
    WAIT
  } state_e;

  // Packed FIFO word: two pixels, even column in the low lane.
  localparam int unsigned FIFO_WORD_WIDTH = 32;
  localparam int unsigned LANE_WIDTH      = 16;
  localparam int unsigned EVEN_LANE_LSB   = 0;
  localparam int unsigned ODD_LANE_LSB    = 16;

  // Rows on either side of the matching window centre.
  function automatic int unsigned window_half(input int unsigned window);
    return window / 2;
  endfunction

endpackage

// File: rtl/bram_row_loader_if.sv
// FIFO pop side, BRAM write ports and calculator handshake of the row loader.
interface bram_row_loader_if
  import bram_row_loader_pkg::*;
#(
  parameter int unsigned BRAM_DATA_WIDTH = 16,
  parameter int unsigned BRAM_ADDR_WIDTH = 13,
  parameter int unsigned BRAM_WE_WIDTH   = 1
) ();

  logic                       start;
  logic [FIFO_WORD_WIDTH-1:0] din_ref_fifo;
  logic                       empty_ref_fifo;
  logic                       rd_en_ref_fifo;
  logic [FIFO_WORD_WIDTH-1:0] din_search_fifo;
  logic                       empty_search_fifo;
  logic                       rd_en_search_fifo;

  logic                       en_ref_w;
  logic [BRAM_WE_WIDTH-1:0]   we_ref_w;
  logic [BRAM_ADDR_WIDTH-1:0] addr_ref_w;
  logic [BRAM_DATA_WIDTH-1:0] din_ref_w;
  logic                       en_search_w;
  logic [BRAM_WE_WIDTH-1:0]   we_search_w;
  logic [BRAM_ADDR_WIDTH-1:0] addr_search_w;
  logic [BRAM_DATA_WIDTH-1:0] din_search_w;

  logic                       go;
  logic                       busy_ref;
  logic                       busy_search;
  logic                       finished_row;
  logic                       row_overrun;

  modport master (
    input  start, din_ref_fifo, empty_ref_fifo, din_search_fifo, empty_search_fifo,
           finished_row,
    output rd_en_ref_fifo, rd_en_search_fifo,
           en_ref_w, we_ref_w, addr_ref_w, din_ref_w,
           en_search_w, we_search_w, addr_search_w, din_search_w,
           go, busy_ref, busy_search, row_overrun
  );

  modport slave (
    output start, din_ref_fifo, empty_ref_fifo, din_search_fifo, empty_search_fifo,
           finished_row,
    input  rd_en_ref_fifo, rd_en_search_fifo,
           en_ref_w, we_ref_w, addr_ref_w, din_ref_w,
           en_search_w, we_search_w, addr_search_w, din_search_w,
           go, busy_ref, busy_search, row_overrun
  );

endinterface

// File: rtl/bram_row_loader.sv
// Copies packed pixel pairs from the reference/search FIFOs into the circular
// line BRAMs: preloads a window of rows, then refills one row per finished_row.
module bram_row_loader
  import bram_row_loader_pkg::*;
#(
  parameter int unsigned NUM_OF_ROWS_IN_BRAM = 8,
  parameter int unsigned VRES                = 480,
  parameter int unsigned HRES                = 640,
  parameter int unsigned BRAM_DATA_WIDTH     = 16,
  parameter int unsigned BRAM_ADDR_WIDTH     = 13,
  parameter int unsigned BRAM_WE_WIDTH       = 1,
  parameter int unsigned window              = 7
) (
  input logic               clk,
  input logic               reset,
  bram_row_loader_if.master bus
);

  localparam int unsigned ROW_W  = $clog2(VRES + 1);
  localparam int unsigned COL_W  = $clog2(HRES + 1);
  localparam int unsigned SLOT_W = (NUM_OF_ROWS_IN_BRAM > 1) ? $clog2(NUM_OF_ROWS_IN_BRAM) : 1;
  localparam int unsigned LEFT_W = $clog2(window + 1);

  state_e                     state_q, state_d;
  logic [ROW_W-1:0]           row_q, row_d;
  logic [COL_W-1:0]           col_q, col_d;
  logic [SLOT_W-1:0]          slot_q, slot_d;
  logic [LEFT_W-1:0]          left_q, left_d;
  logic [BRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                       go_q, go_d;
  logic                       overrun_q, overrun_d;

  logic                       fifos_ready;
  logic                       wr_lo;
  logic                       wr_hi;
  logic                       wr_en;
  logic [BRAM_ADDR_WIDTH-1:0] wr_addr;

  assign fifos_ready = !bus.empty_ref_fifo && !bus.empty_search_fifo;
  assign wr_lo       = (state_q == PRELOAD_LO || state_q == LOAD_LO) && fifos_ready;
  assign wr_hi       = (state_q == PRELOAD_HI || state_q == LOAD_HI);
  assign wr_en       = wr_lo || wr_hi;

  // State and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      row_q     <= '0;
      col_q     <= '0;
      slot_q    <= '0;
      left_q    <= '0;
      addr_q    <= '0;
      go_q      <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      slot_q    <= slot_d;
      left_q    <= left_d;
      addr_q    <= addr_d;
      go_q      <= go_d;
      overrun_q <= overrun_d;
    end
  end

  // Next-state: row/column walk and the registered slot*HRES+col address.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    slot_d    = slot_q;
    left_d    = left_q;
    addr_d    = addr_q;
    go_d      = 1'b0;
    overrun_d = overrun_q || (bus.finished_row && state_q != WAIT);
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = PRELOAD_LO;
          row_d   = '0;
          col_d   = '0;
          slot_d  = '0;
          left_d  = LEFT_W'(window);
          addr_d  = '0;
        end
      end
      PRELOAD_LO: if (fifos_ready) state_d = PRELOAD_HI;
      LOAD_LO:    if (fifos_ready) state_d = LOAD_HI;
      PRELOAD_HI, LOAD_HI: begin
        state_d = (state_q == PRELOAD_HI) ? PRELOAD_LO : LOAD_LO;
        if (32'(col_q) + 2 == HRES) begin
          col_d  = '0;
          row_d  = row_q + ROW_W'(1);
          slot_d = (32'(slot_q) == NUM_OF_ROWS_IN_BRAM - 1) ? '0 : slot_q + SLOT_W'(1);
          left_d = left_q - LEFT_W'(1);
          if (left_q == LEFT_W'(1)) begin
            state_d = WAIT;
            go_d    = (state_q == PRELOAD_HI);
          end
        end else begin
          col_d = col_q + COL_W'(2);
        end
        addr_d = BRAM_ADDR_WIDTH'(32'(slot_d) * HRES + 32'(col_d));
      end
      WAIT: begin
        if (bus.finished_row) begin
          state_d = LOAD_LO;
          if (32'(row_q) < VRES) begin
            left_d = LEFT_W'(1);
          end else begin
            row_d  = '0;
            col_d  = '0;
            slot_d = '0;
            left_d = LEFT_W'(window);
            addr_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Write ports and FIFO pops: low lane in _LO, high lane and pop in _HI.
  always_comb begin
    wr_addr               = wr_hi ? addr_q + BRAM_ADDR_WIDTH'(1) : (wr_lo ? addr_q : '0);
    bus.en_ref_w          = wr_en;
    bus.en_search_w       = wr_en;
    bus.we_ref_w          = {BRAM_WE_WIDTH{wr_en}};
    bus.we_search_w       = {BRAM_WE_WIDTH{wr_en}};
    bus.addr_ref_w        = wr_addr;
    bus.addr_search_w     = wr_addr;
    bus.din_ref_w         = '0;
    bus.din_search_w      = '0;
    if (wr_hi) begin
      bus.din_ref_w    = bus.din_ref_fifo[ODD_LANE_LSB +: BRAM_DATA_WIDTH];
      bus.din_search_w = bus.din_search_fifo[ODD_LANE_LSB +: BRAM_DATA_WIDTH];
    end else if (wr_lo) begin
      bus.din_ref_w    = bus.din_ref_fifo[EVEN_LANE_LSB +: BRAM_DATA_WIDTH];
      bus.din_search_w = bus.din_search_fifo[EVEN_LANE_LSB +: BRAM_DATA_WIDTH];
    end
    bus.rd_en_ref_fifo    = wr_hi;
    bus.rd_en_search_fifo = wr_hi;
  end

  // Calculator handshake; busy reacts to finished_row in the same cycle.
  always_comb begin
    bus.busy_ref    = (state_q != WAIT) || bus.finished_row;
    bus.busy_search = (state_q != WAIT) || bus.finished_row;
    bus.go          = go_q;
    bus.row_overrun = overrun_q;
  end

endmodule

// File: tb/tb_bram_row_loader.sv
// Directed-sequence bench with random pixel data and a row-level write model.
module tb_bram_row_loader;

  localparam int unsigned NR = 4, VR = 16, HR = 16, WIN = 3;
  localparam int unsigned DW = 16, AW = 13, WEW = 1, NWORDS = 300;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  bram_row_loader_if #(.BRAM_DATA_WIDTH(DW), .BRAM_ADDR_WIDTH(AW), .BRAM_WE_WIDTH(WEW)) bus ();

  bram_row_loader #(
    .NUM_OF_ROWS_IN_BRAM(NR), .VRES(VR), .HRES(HR), .BRAM_DATA_WIDTH(DW),
    .BRAM_ADDR_WIDTH(AW), .BRAM_WE_WIDTH(WEW), .window(WIN)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    int unsigned addr;
    int unsigned k;
    bit          hi;
    bit          last_pre;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] wref [NWORDS];
  logic [31:0] wsrch[NWORDS];
  int unsigned rp, ep, next_row, gap;
  bit          started, go_next, overrun_exp, last_pop;
  int          checks, errors;
  int unsigned wr_seen, pop_seen, go_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Queue the 2*HR/2 writes of frame row r, consuming FIFO words in order.
  task automatic add_row(input int unsigned r, input bit last_of_preload);
    for (int unsigned c = 0; c < HR; c += 2) begin
      exp_t e;
      e.addr = (r % NR) * HR + c;
      e.k = ep; e.hi = 1'b0; e.last_pre = 1'b0;
      exp_q.push_back(e);
      e.addr = e.addr + 1; e.hi = 1'b1;
      e.last_pre = last_of_preload && (c + 2 == HR);
      exp_q.push_back(e);
      ep++;
    end
  endtask

  task automatic cyc(input bit st, input bit fr);
    bit waiting, arm, exp_wr, exp_pop, exp_busy;
    logic [31:0] w, ws, d_ref, d_srch;
    exp_t e;
    @(negedge clk);
    waiting = started && exp_q.size() == 0;
    arm = 1'b0;
    if (st && !started) begin
      started = 1'b1;
      arm = 1'b1;
      for (int unsigned r = 0; r < WIN; r++) add_row(r, r == WIN - 1);
      next_row = WIN;
    end
    if (fr && waiting) begin
      arm = 1'b1;
      if (next_row < VR) begin
        add_row(next_row, 1'b0);
        next_row++;
      end else begin
        for (int unsigned r = 0; r < WIN; r++) add_row(r, 1'b0);
        next_row = WIN;
      end
    end
    bus.start             = st;
    bus.finished_row      = fr;
    bus.empty_ref_fifo    = (rp >= NWORDS);
    bus.din_ref_fifo      = (rp < NWORDS) ? wref[rp] : 32'h0;
    bus.empty_search_fifo = (rp >= NWORDS) || (gap > 0);
    bus.din_search_fifo   = (rp < NWORDS && gap == 0) ? wsrch[rp] : 32'hDEAD_BEEF;
    #1;
    exp_wr   = !arm && exp_q.size() > 0 && (exp_q[0].hi || (rp < NWORDS && gap == 0));
    exp_pop  = exp_wr && exp_q[0].hi;
    exp_busy = fr || !started || exp_q.size() > 0;
    chk("busy_ref", bus.busy_ref, exp_busy);
    chk("busy_search", bus.busy_search, exp_busy);
    chk("go", bus.go, go_next);
    chk("row_overrun", bus.row_overrun, overrun_exp);
    chk("en_ref_w", bus.en_ref_w, exp_wr);
    chk("en_search_w", bus.en_search_w, exp_wr);
    chk("we_ref_w", bus.we_ref_w, exp_wr);
    chk("rd_en_ref", bus.rd_en_ref_fifo, exp_pop);
    chk("rd_en_search", bus.rd_en_search_fifo, exp_pop);
    if (bus.en_ref_w === 1'b1) wr_seen++;
    if (bus.rd_en_ref_fifo === 1'b1) pop_seen++;
    if (bus.go === 1'b1) go_seen++;
    go_next = 1'b0;
    if (exp_wr) begin
      e = exp_q.pop_front();
      w = wref[e.k];
      ws = wsrch[e.k];
      d_ref  = e.hi ? {16'h0, w[31:16]}  : {16'h0, w[15:0]};
      d_srch = e.hi ? {16'h0, ws[31:16]} : {16'h0, ws[15:0]};
      chk("addr_ref_w", bus.addr_ref_w, e.addr);
      chk("addr_search_w", bus.addr_search_w, e.addr);
      chk("din_ref_w", bus.din_ref_w, d_ref);
      chk("din_search_w", bus.din_search_w, d_srch);
      go_next = e.last_pre;
    end
    @(posedge clk);
    if (fr && !waiting) overrun_exp = 1'b1;
    last_pop = exp_pop;
    if (exp_pop) rp++;
    if (gap > 0) gap--;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.start = 1'b0;
    bus.finished_row = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_en_ref", bus.en_ref_w, 0);
    chk("rst_en_search", bus.en_search_w, 0);
    chk("rst_we_ref", bus.we_ref_w, 0);
    chk("rst_we_search", bus.we_search_w, 0);
    chk("rst_addr_ref", bus.addr_ref_w, 0);
    chk("rst_addr_search", bus.addr_search_w, 0);
    chk("rst_din_ref", bus.din_ref_w, 0);
    chk("rst_din_search", bus.din_search_w, 0);
    chk("rst_rd_en_ref", bus.rd_en_ref_fifo, 0);
    chk("rst_rd_en_search", bus.rd_en_search_fifo, 0);
    chk("rst_go", bus.go, 0);
    chk("rst_overrun", bus.row_overrun, 0);
    chk("rst_busy_ref", bus.busy_ref, 1);
    chk("rst_busy_search", bus.busy_search, 1);
    exp_q.delete();
    started = 1'b0; go_next = 1'b0; overrun_exp = 1'b0; gap = 0;
    next_row = 0; ep = rp;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      cyc(1'b0, 1'b0);
      n++;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  initial begin
    checks = 0; errors = 0; rp = 0; ep = 0; gap = 0;
    started = 0; go_next = 0; overrun_exp = 0; next_row = 0;
    bus.start = 1'b0; bus.finished_row = 1'b0;
    bus.empty_ref_fifo = 1'b1; bus.empty_search_fifo = 1'b1;
    bus.din_ref_fifo = '0; bus.din_search_fifo = '0;
    for (int i = 0; i < NWORDS; i++) begin
      wref[i]  = $urandom;
      wsrch[i] = $urandom;
    end
    do_reset();
    cyc(1'b0, 1'b0);

    // First-frame preload: rows 0..2 into addresses 0..47.
    wr_seen = 0; pop_seen = 0; go_seen = 0;
    cyc(1'b1, 1'b0);
    run_until_idle("preload_timeout", 200);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    chk("preload_writes", wr_seen, 48);
    chk("preload_pops", pop_seen, 24);
    chk("preload_go_count", go_seen, 1);

    // One refill: row 3 into addresses 48..63.
    wr_seen = 0;
    cyc(1'b0, 1'b1);
    run_until_idle("row3_timeout", 100);
    cyc(1'b0, 1'b0);
    chk("row3_writes", wr_seen, 16);

    // Row 4 with a stray start and a 5-cycle search FIFO gap mid-row.
    wr_seen = 0; pop_seen = 0;
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    for (int i = 0; i < 20 && pop_seen < 3; i++) cyc(1'b0, 1'b0);
    gap = 5;
    run_until_idle("gap_timeout", 100);
    cyc(1'b0, 1'b0);
    chk("row4_writes", wr_seen, 16);
    chk("row4_pops", pop_seen, 8);

    // Rows 5..15, with a finished_row during a high-lane write on row 10.
    for (int r = 5; r < 16; r++) begin
      cyc(1'b0, 1'b1);
      if (r == 10) begin
        for (int i = 0; i < 10 && exp_q.size() > 0 && !exp_q[0].hi; i++) cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
      end
      run_until_idle("row_timeout", 100);
      cyc(1'b0, 1'b0);
    end
    chk("overrun_sticky", bus.row_overrun, 1);

    // Frame end: rows 0..2 reloaded into slots 0..2, no go.
    wr_seen = 0; go_seen = 0;
    cyc(1'b0, 1'b1);
    run_until_idle("frame_end_timeout", 200);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    chk("frame_end_writes", wr_seen, 48);
    chk("frame_end_go_count", go_seen, 0);

    // Reset partway through row 3, then restart from address 0.
    cyc(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0);
    do_reset();
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    wr_seen = 0; go_seen = 0;
    cyc(1'b1, 1'b0);
    run_until_idle("restart_timeout", 200);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    chk("restart_writes", wr_seen, 48);
    chk("restart_go_count", go_seen, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bram_row_loader.md
Name: bram_row_loader

Overview:
- Upstream feeder for the disparity-map calculator.
- Pops packed pixel words from two first-word-fall-through FIFOs (reference camera, search camera) and writes them into the two circular line BRAMs on the write port.
- Preloads the first `window` rows of a frame, pulses `go`, then refills one row per `finished_row` pulse.
- Holds `busy_ref`/`busy_search` high whenever the BRAM contents are not valid for the calculator.

Parameters:
- NUM_OF_ROWS_IN_BRAM, 8, circular row slots per BRAM; must be >= window+1.
- VRES, 480, rows per frame.
- HRES, 640, pixels per row; must be even.
- BRAM_DATA_WIDTH, 16, pixel width.
- BRAM_ADDR_WIDTH, 13, BRAM address width; NUM_OF_ROWS_IN_BRAM*HRES must fit.
- BRAM_WE_WIDTH, 1, write-enable width.
- window, 7, matching window size (odd); window_half = window/2.

Ports:
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; arms loading of the first frame.
- din_ref_fifo  in  32  reference FIFO head word: [15:0] = even column, [31:16] = odd column.
- empty_ref_fifo  in  1  reference FIFO empty.
- rd_en_ref_fifo  out  1  reference FIFO pop.
- din_search_fifo  in  32  search FIFO head word, same packing.
- empty_search_fifo  in  1  search FIFO empty.
- rd_en_search_fifo  out  1  search FIFO pop.
- en_ref_w  out  1  reference BRAM write-port enable.
- we_ref_w  out  BRAM_WE_WIDTH  reference write enable.
- addr_ref_w  out  BRAM_ADDR_WIDTH  reference write address.
- din_ref_w  out  BRAM_DATA_WIDTH  reference write data.
- en_search_w, we_search_w, addr_search_w, din_search_w  out  same widths  search BRAM write port.
- go  out  1  one-cycle pulse: first-frame preload complete.
- busy_ref  out  1  reference BRAM not ready.
- busy_search  out  1  search BRAM not ready; always equal to busy_ref.
- finished_row  in  1  pulse from the calculator: one output row done.
- row_overrun  out  1  sticky error flag.

Behaviour:
- Reset values: state IDLE, all enables/we/rd_en 0, addresses/data 0, go 0, row_overrun 0, row counter 0, col counter 0, pending 0.
- busy_ref = busy_search = (state != WAIT) | finished_row. This is combinational, so the calculator stalls in the same cycle the pulse appears. It reads 1 during and after reset, until the first WAIT.
- States:
  - IDLE: on start -> PRELOAD_LO with row=0, col=0, rows_left=window.
  - PRELOAD_LO / LOAD_LO: if both FIFOs are non-empty, write the [15:0] halves to both BRAMs at addr = (row % NUM_OF_ROWS_IN_BRAM)*HRES + col, with en=we=1; go to _HI. Otherwise stall with no writes.
  - _HI: write the [31:16] halves at addr+1; assert both rd_en for exactly this cycle; col += 2.
    - col reaches HRES: col=0, row+1, rows_left-1.
    - rows_left reaches 0: PRELOAD -> WAIT with go pulsed in that transition cycle; LOAD -> WAIT, no go. Otherwise back to _LO.
  - WAIT: on finished_row:
    - If row < VRES: LOAD_LO with rows_left=1.
    - Else (frame end): row=0, rows_left=window, LOAD_LO. No go pulse; the calculator is already past IDLE and resumes on busy deassert.
- Throughput: 2 clocks per FIFO word when data is available. FIFOs are popped only in lockstep, never one alone.
- Slot safety: the row written after centre c is c+window_half+1. It maps to the slot of c-window_half-1, which is no longer used.
- finished_row while not in WAIT: ignored for loading, row_overrun set (sticky until reset).
- start while not in IDLE: ignored.
- Reset mid-row: immediate abort to IDLE. FIFOs are not flushed by this block; partial rows are abandoned.
- din widths: the low BRAM_DATA_WIDTH bits of each half are used.

Decomposition:
- Shared package holds:
  - state enum: IDLE, PRELOAD_LO, PRELOAD_HI, LOAD_LO, LOAD_HI, WAIT;
  - WINDOW_HALF derivation;
  - the pixel-lane packing constants (even lane [15:0], odd lane [31:16]), shared with the calculator's output packing.
- No sub-module. Address generation is a single registered multiply-add inside this block.

Test Plan (HRES=16, VRES=16, window=3, NUM_OF_ROWS_IN_BRAM=4):
- Reset, start, both FIFOs full of ramp data:
  - 24 pops, 48 writes per BRAM, addresses 0..47;
  - go pulses once, exactly one cycle after the last write;
  - busy falls in the same cycle.
- In WAIT, pulse finished_row:
  - busy rises the same cycle and stays high for 16 write cycles;
  - row 3 is written to addresses 48..63;
  - busy falls after the last write.
- Search FIFO empty for 5 cycles mid-row:
  - no writes and no rd_en on either FIFO during the gap;
  - loading resumes without lost or duplicated pixels.
- Drive 13 finished_row pulses through the frame end (rows 3..15 loaded):
  - the next pulse loads rows 0..2 into slots 0..2;
  - busy is held for 48 write cycles;
  - go stays 0.
- finished_row pulsed during LOAD_HI -> row_overrun = 1 and stays set; load sequence unchanged.
- Assert reset mid-row -> all outputs return to reset values; the next start restarts at address 0.
